// File: rtl/datapath.sv
// ---------------------------------------------------------------------------
// datapath
//
// Single-bus 32-bit datapath for the Mini-SRC CPU. Holds PC, IR, MAR, MDR,
// Y, a 64-bit Z, and general registers R1-R3. All transfers happen over one
// shared combinational bus. Each transfer is steered by individual strobes
// from an external control unit, one register transfer per rising edge.
//
// Ports
//   clock        rising-edge clock for every register
//   clear        asynchronous active-low reset, clears every register
//   Mdatain      memory read data, loaded into MDR when Read=1
//   PCout, Zhighout, Zlowout, MDRout, R2out, R3out
//                bus source selects. Priority order:
//                MDR > PC > Zlow > Zhigh > R2 > R3
//   PCin, IRin, MARin, MDRin, Yin, Zin, R1in, R2in, R3in
//                register load enables
//   IncPC        with PCin, increments PC instead of loading the bus
//   Read         MDR input select (1 = Mdatain, 0 = bus)
//   AND          ALU op select (1 = AND, 0 = ADD with carry into Z[32])
//   BusMuxOut    current bus value (combinational)
//   IRq, MARq, R1q  IR, MAR and R1 contents, for observation
// ---------------------------------------------------------------------------
module datapath (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] Mdatain,
  input  logic        PCout,
  input  logic        Zhighout,
  input  logic        Zlowout,
  input  logic        MDRout,
  input  logic        R2out,
  input  logic        R3out,
  input  logic        PCin,
  input  logic        IRin,
  input  logic        MARin,
  input  logic        MDRin,
  input  logic        Yin,
  input  logic        Zin,
  input  logic        R1in,
  input  logic        R2in,
  input  logic        R3in,
  input  logic        IncPC,
  input  logic        Read,
  input  logic        AND,
  output logic [31:0] BusMuxOut,
  output logic [31:0] IRq,
  output logic [31:0] MARq,
  output logic [31:0] R1q
);

  logic [31:0] pc_q,  pc_d;
  logic [31:0] ir_q,  ir_d;
  logic [31:0] mar_q, mar_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] y_q,   y_d;
  logic [63:0] z_q,   z_d;
  logic [31:0] r1_q,  r1_d;
  logic [31:0] r2_q,  r2_d;
  logic [31:0] r3_q,  r3_d;

  logic [32:0] aluSum;
  logic [63:0] aluC;

  // Bus multiplexer. When several selects are high, the first match in this
  // chain wins. With no select high, the bus reads zero.
  always_comb begin
    if (MDRout)        BusMuxOut = mdr_q;
    else if (PCout)    BusMuxOut = pc_q;
    else if (Zlowout)  BusMuxOut = z_q[31:0];
    else if (Zhighout) BusMuxOut = z_q[63:32];
    else if (R2out)    BusMuxOut = r2_q;
    else if (R3out)    BusMuxOut = r3_q;
    else               BusMuxOut = 32'h0;
  end

  // ALU: A is Y, B is the bus. ADD keeps its carry-out in bit 32 of the
  // result, so Zhighout can expose the carry.
  assign aluSum = {1'b0, y_q} + {1'b0, BusMuxOut};

  always_comb begin
    if (AND) aluC = {32'h0, y_q & BusMuxOut};
    else     aluC = {31'h0, aluSum};
  end

  // Next-state selection. Every register holds unless its enable is high.
  // A register that is both source and destination reloads its own value.
  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    mar_d = mar_q;
    mdr_d = mdr_q;
    y_d   = y_q;
    z_d   = z_q;
    r1_d  = r1_q;
    r2_d  = r2_q;
    r3_d  = r3_q;

    if (PCin)  pc_d  = IncPC ? (pc_q + 32'd1) : BusMuxOut;
    if (IRin)  ir_d  = BusMuxOut;
    if (MARin) mar_d = BusMuxOut;
    if (MDRin) mdr_d = Read ? Mdatain : BusMuxOut;
    if (Yin)   y_d   = BusMuxOut;
    if (Zin)   z_d   = aluC;
    if (R1in)  r1_d  = BusMuxOut;
    if (R2in)  r2_d  = BusMuxOut;
    if (R3in)  r3_d  = BusMuxOut;
  end

  // Register bank. clear wipes everything immediately, without waiting
  // for a clock edge.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      pc_q  <= 32'h0;
      ir_q  <= 32'h0;
      mar_q <= 32'h0;
      mdr_q <= 32'h0;
      y_q   <= 32'h0;
      z_q   <= 64'h0;
      r1_q  <= 32'h0;
      r2_q  <= 32'h0;
      r3_q  <= 32'h0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      y_q   <= y_d;
      z_q   <= z_d;
      r1_q  <= r1_d;
      r2_q  <= r2_d;
      r3_q  <= r3_d;
    end
  end

  assign IRq  = ir_q;
  assign MARq = mar_q;
  assign R1q  = r1_q;

endmodule

// File: tb/tb_datapath.sv
// ---------------------------------------------------------------------------
// tb_datapath
//
// Self-checking bench for the Mini-SRC datapath. A behavioural model of the
// register file tracks the expected contents of every register. Directed
// scenarios follow the CPU's fetch/execute sequences. A randomized phase
// then drives arbitrary strobe combinations against the model.
// ---------------------------------------------------------------------------
module tb_datapath;

  logic        clock;
  logic        clear;
  logic [31:0] Mdatain;
  logic        PCout, Zhighout, Zlowout, MDRout, R2out, R3out;
  logic        PCin, IRin, MARin, MDRin, Yin, Zin, R1in, R2in, R3in;
  logic        IncPC, Read, AND;
  logic [31:0] BusMuxOut, IRq, MARq, R1q;

  int vectors     = 0;
  int miscompares = 0;

  // Expected register contents
  logic [31:0] mPc, mIr, mMar, mMdr, mY, mR1, mR2, mR3;
  logic [63:0] mZ;

  datapath dut (
    .clock(clock), .clear(clear), .Mdatain(Mdatain),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .MDRout(MDRout), .R2out(R2out), .R3out(R3out),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
    .Yin(Yin), .Zin(Zin), .R1in(R1in), .R2in(R2in), .R3in(R3in),
    .IncPC(IncPC), .Read(Read), .AND(AND),
    .BusMuxOut(BusMuxOut), .IRq(IRq), .MARq(MARq), .R1q(R1q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Bus value implied by the current selects and the model's registers
  function automatic logic [31:0] modelBus();
    if (MDRout)   return mMdr;
    if (PCout)    return mPc;
    if (Zlowout)  return mZ[31:0];
    if (Zhighout) return mZ[63:32];
    if (R2out)    return mR2;
    if (R3out)    return mR3;
    return 32'h0;
  endfunction

  task automatic modelClear();
    mPc = 0; mIr = 0; mMar = 0; mMdr = 0; mY = 0;
    mR1 = 0; mR2 = 0; mR3 = 0; mZ = 64'h0;
  endtask

  task automatic idle();
    PCout = 0; Zhighout = 0; Zlowout = 0; MDRout = 0; R2out = 0; R3out = 0;
    PCin = 0; IRin = 0; MARin = 0; MDRin = 0; Yin = 0; Zin = 0;
    R1in = 0; R2in = 0; R3in = 0; IncPC = 0; Read = 0; AND = 0;
  endtask

  // Advance the model by one register transfer, then let the DUT take the edge.
  task automatic tick();
    logic [31:0] b;
    logic [63:0] c;
    b = modelBus();
    c = AND ? {32'h0, mY & b} : (64'(mY) + 64'(b));
    if (clear) begin
      if (PCin)  mPc  = IncPC ? mPc + 32'd1 : b;
      if (IRin)  mIr  = b;
      if (MARin) mMar = b;
      if (MDRin) mMdr = Read ? Mdatain : b;
      if (Yin)   mY   = b;
      if (Zin)   mZ   = c;
      if (R1in)  mR1  = b;
      if (R2in)  mR2  = b;
      if (R3in)  mR3  = b;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic loadMdr(input logic [31:0] v);
    idle(); Mdatain = v; Read = 1; MDRin = 1; tick(); idle();
  endtask

  task automatic test_reset();
    clear = 0;
    for (int i = 0; i < 4; i++) begin
      {PCout, Zhighout, Zlowout, MDRout, R2out, R3out} = 6'($urandom);
      {PCin, IRin, MARin, MDRin, Yin, Zin, R1in, R2in, R3in} = 9'($urandom);
      {IncPC, Read, AND} = 3'($urandom);
      Mdatain = $urandom;
      tick();
    end
    modelClear();
    #2 clear = 1;
    idle();
    #1;
    vectors++;
    if (BusMuxOut !== 32'h0) begin
      $display("[TB] FAIL reset_bus actual=%h required=%h", BusMuxOut, 32'h0); miscompares++;
    end
    vectors++;
    if (IRq !== 32'h0) begin
      $display("[TB] FAIL reset_ir actual=%h required=%h", IRq, 32'h0); miscompares++;
    end
    vectors++;
    if (MARq !== 32'h0) begin
      $display("[TB] FAIL reset_mar actual=%h required=%h", MARq, 32'h0); miscompares++;
    end
    vectors++;
    if (R1q !== 32'h0) begin
      $display("[TB] FAIL reset_r1 actual=%h required=%h", R1q, 32'h0); miscompares++;
    end
    PCout = 1; #1;
    vectors++;
    if (BusMuxOut !== 32'h0) begin
      $display("[TB] FAIL reset_pc actual=%h required=%h", BusMuxOut, 32'h0); miscompares++;
    end
    idle();
  endtask

  task automatic test_register_load();
    loadMdr(32'h12); MDRout = 1; R2in = 1; tick(); idle();
    loadMdr(32'h14); MDRout = 1; R3in = 1; tick(); idle();
    loadMdr(32'h18); MDRout = 1; R1in = 1; tick(); idle();
    #1;
    vectors++;
    if (R1q !== 32'h18) begin
      $display("[TB] FAIL load_r1 actual=%h required=%h", R1q, 32'h18); miscompares++;
    end
    R2out = 1; #1;
    vectors++;
    if (BusMuxOut !== 32'h12) begin
      $display("[TB] FAIL load_r2 actual=%h required=%h", BusMuxOut, 32'h12); miscompares++;
    end
    R2out = 0; R3out = 1; #1;
    vectors++;
    if (BusMuxOut !== 32'h14) begin
      $display("[TB] FAIL load_r3 actual=%h required=%h", BusMuxOut, 32'h14); miscompares++;
    end
    idle();
  endtask

  task automatic test_fetch();
    PCout = 1; MARin = 1; tick(); idle();
    vectors++;
    if (MARq !== 32'h0) begin
      $display("[TB] FAIL fetch_mar actual=%h required=%h", MARq, 32'h0); miscompares++;
    end
    PCin = 1; IncPC = 1; tick(); idle();
    PCout = 1; #1;
    vectors++;
    if (BusMuxOut !== 32'h1) begin
      $display("[TB] FAIL fetch_pcinc actual=%h required=%h", BusMuxOut, 32'h1); miscompares++;
    end
    loadMdr(32'h28918000); MDRout = 1; IRin = 1; tick(); idle();
    vectors++;
    if (IRq !== 32'h28918000) begin
      $display("[TB] FAIL fetch_ir actual=%h required=%h", IRq, 32'h28918000); miscompares++;
    end
  endtask

  task automatic test_and_execute();
    R2out = 1; Yin = 1; tick(); idle();
    R3out = 1; AND = 1; Zin = 1; tick(); idle();
    Zlowout = 1; R1in = 1; tick(); idle();
    vectors++;
    if (R1q !== 32'h10) begin
      $display("[TB] FAIL and_r1 actual=%h required=%h", R1q, 32'h10); miscompares++;
    end
    Zhighout = 1; #1;
    vectors++;
    if (BusMuxOut !== 32'h0) begin
      $display("[TB] FAIL and_zhigh actual=%h required=%h", BusMuxOut, 32'h0); miscompares++;
    end
    idle();
  endtask

  task automatic test_add_priority();
    loadMdr(32'hFFFFFFFF); MDRout = 1; Yin = 1; tick(); idle();
    loadMdr(32'h1); MDRout = 1; AND = 0; Zin = 1; tick(); idle();
    Zhighout = 1; #1;
    vectors++;
    if (BusMuxOut !== 32'h1) begin
      $display("[TB] FAIL add_carry actual=%h required=%h", BusMuxOut, 32'h1); miscompares++;
    end
    Zhighout = 0; Zlowout = 1; #1;
    vectors++;
    if (BusMuxOut !== 32'h0) begin
      $display("[TB] FAIL add_low actual=%h required=%h", BusMuxOut, 32'h0); miscompares++;
    end
    idle(); MDRout = 1; R2out = 1; #1;
    vectors++;
    if (BusMuxOut !== 32'h1) begin
      $display("[TB] FAIL prio_mdr_r2 actual=%h required=%h", BusMuxOut, 32'h1); miscompares++;
    end
    MDRout = 0; Zhighout = 1; #1;
    vectors++;
    if (BusMuxOut !== 32'h1) begin
      $display("[TB] FAIL prio_zhigh_r2 actual=%h required=%h", BusMuxOut, 32'h1); miscompares++;
    end
    idle(); #1;
    vectors++;
    if (BusMuxOut !== 32'h0) begin
      $display("[TB] FAIL prio_none actual=%h required=%h", BusMuxOut, 32'h0); miscompares++;
    end
    // A register named as both source and destination keeps its value
    R2out = 1; R2in = 1; tick(); idle();
    R2out = 1; #1;
    vectors++;
    if (BusMuxOut !== 32'h12) begin
      $display("[TB] FAIL self_r2 actual=%h required=%h", BusMuxOut, 32'h12); miscompares++;
    end
    idle();
  endtask

  task automatic test_pc_edges();
    loadMdr(32'hFFFFFFFF); MDRout = 1; PCin = 1; tick(); idle();
    PCin = 1; IncPC = 1; tick(); idle();
    PCout = 1; #1;
    vectors++;
    if (BusMuxOut !== 32'h0) begin
      $display("[TB] FAIL pc_wrap actual=%h required=%h", BusMuxOut, 32'h0); miscompares++;
    end
    idle(); IncPC = 1; tick(); idle();
    PCout = 1; #1;
    vectors++;
    if (BusMuxOut !== 32'h0) begin
      $display("[TB] FAIL pc_incpc_alone actual=%h required=%h", BusMuxOut, 32'h0); miscompares++;
    end
    idle(); R3out = 1; PCin = 1; tick(); idle();
    PCout = 1; #1;
    vectors++;
    if (BusMuxOut !== 32'h14) begin
      $display("[TB] FAIL pc_from_r3 actual=%h required=%h", BusMuxOut, 32'h14); miscompares++;
    end
    idle();
  endtask

  task automatic test_random();
    logic [31:0] expBus;
    for (int i = 0; i < 400; i++) begin
      idle();
      PCout = ($urandom_range(3) == 0); Zhighout = ($urandom_range(3) == 0);
      Zlowout = ($urandom_range(3) == 0); MDRout = ($urandom_range(4) == 0);
      R2out = ($urandom_range(3) == 0); R3out = ($urandom_range(3) == 0);
      PCin = ($urandom_range(2) == 0); IRin = ($urandom_range(2) == 0);
      MARin = ($urandom_range(2) == 0); MDRin = ($urandom_range(2) == 0);
      Yin = ($urandom_range(2) == 0); Zin = ($urandom_range(2) == 0);
      R1in = ($urandom_range(2) == 0); R2in = ($urandom_range(2) == 0);
      R3in = ($urandom_range(2) == 0);
      IncPC = 1'($urandom); Read = 1'($urandom); AND = 1'($urandom);
      Mdatain = $urandom;
      #2;
      expBus = modelBus();
      vectors++;
      if (BusMuxOut !== expBus) begin
        $display("[TB] FAIL rand_bus[%0d] actual=%h required=%h", i, BusMuxOut, expBus); miscompares++;
      end
      tick();
      vectors++;
      if (IRq !== mIr) begin
        $display("[TB] FAIL rand_ir[%0d] actual=%h required=%h", i, IRq, mIr); miscompares++;
      end
      vectors++;
      if (MARq !== mMar) begin
        $display("[TB] FAIL rand_mar[%0d] actual=%h required=%h", i, MARq, mMar); miscompares++;
      end
      vectors++;
      if (R1q !== mR1) begin
        $display("[TB] FAIL rand_r1[%0d] actual=%h required=%h", i, R1q, mR1); miscompares++;
      end
    end
    idle();
  endtask

  // Clear pulse between edges must zero the registers without a clock edge
  task automatic test_midreset();
    loadMdr(32'hA5A5_0001); MDRout = 1; R1in = 1; R2in = 1; R3in = 1; tick(); idle();
    #2 clear = 0;
    modelClear();
    #1;
    vectors++;
    if (R1q !== 32'h0) begin
      $display("[TB] FAIL midreset_r1 actual=%h required=%h", R1q, 32'h0); miscompares++;
    end
    R2out = 1; #1;
    vectors++;
    if (BusMuxOut !== 32'h0) begin
      $display("[TB] FAIL midreset_r2 actual=%h required=%h", BusMuxOut, 32'h0); miscompares++;
    end
    R2out = 0; R3out = 1; #1;
    vectors++;
    if (BusMuxOut !== 32'h0) begin
      $display("[TB] FAIL midreset_r3 actual=%h required=%h", BusMuxOut, 32'h0); miscompares++;
    end
    idle();
    clear = 1;
    loadMdr(32'h77); MDRout = 1; R1in = 1; tick(); idle();
    vectors++;
    if (R1q !== 32'h77) begin
      $display("[TB] FAIL after_reset_r1 actual=%h required=%h", R1q, 32'h77); miscompares++;
    end
  endtask

  initial begin
    clear = 0;
    Mdatain = 0;
    idle();
    modelClear();
    @(negedge clock);
    test_reset();
    test_register_load();
    test_fetch();
    test_and_execute();
    test_add_priority();
    test_pc_edges();
    test_random();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
